// File: rtl/score_display.sv
// Score counter with frame-synchronous double-dabble conversion and a scaled 8x12 digit renderer.
// Digits are latched only at the end of a conversion, so the picture never tears mid-frame.
//
// state | meaning
// IDLE  | waiting for frame_start; displayed digits stable
// SHIFT | one double-dabble step per cycle, SW cycles
// DONE  | publish BCD nibbles to the displayed digits, drop busy
module score_display #(
    parameter int X0         = 0,
    parameter int Y0         = 0,
    parameter int NUM_DIGITS = 2,
    parameter int SCALE_LOG2 = 0,
    parameter int GAP        = 4,
    parameter int MAX_SCORE  = 99,
    parameter int WRAP       = 0,
    parameter int BLANK_LZ   = 1,
    localparam int SW        = $clog2(MAX_SCORE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [11:0]   x,
    input  logic [11:0]   y,
    input  logic          frame_start,
    input  logic          point,
    input  logic          clear,
    output logic [SW-1:0] score,
    output logic          busy,
    output logic          pix
);
    localparam int BW    = 4 * NUM_DIGITS;
    localparam int CW    = 8 << SCALE_LOG2;
    localparam int CH    = 12 << SCALE_LOG2;
    localparam int PITCH = CW + GAP;
    localparam int CNTW  = $clog2(SW + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [SW-1:0]   shreg;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   bcd_adj;
    logic [15:0]     bcd_pad;
    logic [CNTW-1:0] cnt;
    logic [3:0]      digit [4];
    logic [3:0]      blank_lz;

    logic            hit_c, hit_q;
    logic [1:0]      nib_c, nib_q;
    logic [2:0]      col_c, col_q;
    logic [3:0]      row_c, row_q;
    logic [7:0]      glyph_bits;

    function automatic logic [BW-1:0] dabble(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Font rows packed MSB-first: row 0 in bits [95:88], bit 7 of each row is the leftmost column.
    function automatic logic [7:0] glyph_row(input logic [3:0] d, input logic [3:0] r);
        logic [95:0] f;
        int          idx;
        case (d)
            4'd0:    f = 96'h3C_66_66_66_66_66_66_66_66_66_66_3C;
            4'd1:    f = 96'h18_38_18_18_18_18_18_18_18_18_18_3C;
            4'd2:    f = 96'h3C_66_06_0C_18_30_60_40_40_40_7E_7E;
            4'd3:    f = 96'h3C_66_06_06_1C_1C_06_06_06_66_66_3C;
            4'd4:    f = 96'h0C_1C_2C_4C_8C_FE_FE_0C_0C_0C_0C_1E;
            4'd5:    f = 96'h7E_7E_60_60_3C_06_06_06_06_66_66_3C;
            4'd6:    f = 96'h3C_66_60_60_7C_66_66_66_66_66_66_3C;
            4'd7:    f = 96'h7E_7E_06_0C_18_30_30_30_30_30_30_30;
            4'd8:    f = 96'h3C_66_66_66_3C_3C_66_66_66_66_66_3C;
            4'd9:    f = 96'h3C_66_66_66_66_3E_06_06_06_06_66_3C;
            default: f = '0;
        endcase
        if (r > 4'd11)
            return 8'h00;
        idx = 88 - 8 * int'(r);
        return f[idx +: 8];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
        end else if (clear) begin
            score <= '0;
        end else if (point) begin
            if (score == SW'(MAX_SCORE))
                score <= (WRAP != 0) ? '0 : score;
            else
                score <= score + 1'b1;
        end
    end

    assign bcd_adj = dabble(bcd);
    assign bcd_pad = 16'(bcd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            shreg <= '0;
            bcd   <= '0;
            cnt   <= '0;
            for (int j = 0; j < 4; j++)
                digit[j] <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        shreg <= score;
                        bcd   <= '0;
                        cnt   <= CNTW'(SW - 1);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd   <= {bcd_adj[BW-2:0], shreg[SW-1]};
                    shreg <= shreg << 1;
                    if (cnt == '0)
                        state <= DONE;
                    else
                        cnt <= cnt - 1'b1;
                end
                DONE: begin
                    // digit[] is indexed by nibble: 0 = least significant (rightmost) digit
                    for (int j = 0; j < 4; j++)
                        digit[j] <= bcd_pad[4*j +: 4];
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        logic       zero_above;
        blank_lz   = '0;
        zero_above = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            zero_above  = zero_above && (digit[i] == 4'd0);
            blank_lz[i] = (BLANK_LZ != 0) && (i != 0) && zero_above;
        end
    end

    always_comb begin
        logic [12:0] x13, y13, cx, dx, dy;
        hit_c = 1'b0;
        nib_c = '0;
        col_c = '0;
        row_c = '0;
        x13   = {1'b0, x};
        y13   = {1'b0, y};
        cx    = '0;
        dx    = '0;
        dy    = y13 - 13'(Y0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            cx = 13'(X0 + k * PITCH);
            dx = x13 - cx;
            if (!hit_c && x13 >= cx && dx < 13'(CW) && y13 >= 13'(Y0) && dy < 13'(CH)) begin
                hit_c = 1'b1;
                nib_c = 2'(NUM_DIGITS - 1 - k);
                col_c = dx[SCALE_LOG2 +: 3];
                row_c = dy[SCALE_LOG2 +: 4];
            end
        end
    end

    assign glyph_bits = glyph_row(digit[nib_q], row_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= 1'b0;
            nib_q <= '0;
            col_q <= '0;
            row_q <= '0;
            pix   <= 1'b0;
        end else begin
            hit_q <= hit_c;
            nib_q <= nib_c;
            col_q <= col_c;
            row_q <= row_c;
            pix   <= hit_q && !blank_lz[nib_q] && glyph_bits[3'd7 - col_q];
        end
    end
endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: two instances (default geometry / scaled+wrapping) against an arithmetic reference model.
module tb_score_display;
    localparam int SW  = 7;
    localparam int MAX = 99;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] x, y;
    logic        frame_start, point, clear;
    logic [SW-1:0] score0, score1;
    logic        busy0, busy1, pix0, pix1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    score_display dut0 (
        .clk(clk), .rst(rst), .x(x), .y(y), .frame_start(frame_start), .point(point), .clear(clear),
        .score(score0), .busy(busy0), .pix(pix0)
    );

    score_display #(.X0(100), .Y0(50), .SCALE_LOG2(1), .WRAP(1), .BLANK_LZ(0)) dut1 (
        .clk(clk), .rst(rst), .x(x), .y(y), .frame_start(frame_start), .point(point), .clear(clear),
        .score(score1), .busy(busy1), .pix(pix1)
    );

    // reference model state, index 0 -> dut0, 1 -> dut1
    int p_x0 [2] = '{0, 100};
    int p_y0 [2] = '{0, 50};
    int p_s  [2] = '{0, 1};
    int p_wrap [2] = '{0, 1};
    int p_blz [2] = '{1, 0};
    int m_score [2], m_cnt [2], m_snap [2], m_disp [2], m_pix [2];
    int s1_valid, s1x, s1y;
    logic [95:0] font [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_pix(int i, int px, int py, int shown);
        int cw, ch, cx, d, col, row;
        cw = 8 << p_s[i];
        ch = 12 << p_s[i];
        for (int k = 0; k < 2; k++) begin
            cx = p_x0[i] + k * (cw + 4);
            if (px >= cx && px < cx + cw && py >= p_y0[i] && py < p_y0[i] + ch) begin
                d = (k == 0) ? shown / 10 : shown % 10;
                if (p_blz[i] != 0 && k == 0 && d == 0)
                    return 0;
                col = (px - cx) >> p_s[i];
                row = (py - p_y0[i]) >> p_s[i];
                return font[d][95 - 8 * row - col] ? 1 : 0;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_score[i] = 0; m_cnt[i] = 0; m_snap[i] = 0; m_disp[i] = 0; m_pix[i] = 0;
        end
        s1_valid = 0; s1x = 0; s1y = 0;
    endtask

    task automatic model_edge();
        int newpix;
        for (int i = 0; i < 2; i++) begin
            newpix = (s1_valid != 0) ? ref_pix(i, s1x, s1y, m_disp[i]) : 0;
            if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0)
                    m_disp[i] = m_snap[i];
            end else if (frame_start) begin
                m_cnt[i]  = SW + 1;
                m_snap[i] = m_score[i];
            end
            if (clear)
                m_score[i] = 0;
            else if (point)
                m_score[i] = (m_score[i] == MAX) ? ((p_wrap[i] != 0) ? 0 : MAX) : m_score[i] + 1;
            m_pix[i] = newpix;
        end
        s1_valid = 1; s1x = int'(x); s1y = int'(y);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("score0", 32'(score0), 32'(m_score[0]));
        chk("score1", 32'(score1), 32'(m_score[1]));
        chk("busy0", 32'(busy0), 32'(m_cnt[0] > 0));
        chk("busy1", 32'(busy1), 32'(m_cnt[1] > 0));
        chk("pix0", 32'(pix0), 32'(m_pix[0]));
        chk("pix1", 32'(pix1), 32'(m_pix[1]));
    endtask

    task automatic pulse_frame_and_settle();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        repeat (10) step();
    endtask

    task automatic hold_xy(input int xx, input int yy);
        x = 12'(xx); y = 12'(yy);
        step(); step();
    endtask

    initial begin
        int n;
        font[0] = 96'h3C_66_66_66_66_66_66_66_66_66_66_3C;
        font[1] = 96'h18_38_18_18_18_18_18_18_18_18_18_3C;
        font[2] = 96'h3C_66_06_0C_18_30_60_40_40_40_7E_7E;
        font[3] = 96'h3C_66_06_06_1C_1C_06_06_06_66_66_3C;
        font[4] = 96'h0C_1C_2C_4C_8C_FE_FE_0C_0C_0C_0C_1E;
        font[5] = 96'h7E_7E_60_60_3C_06_06_06_06_66_66_3C;
        font[6] = 96'h3C_66_60_60_7C_66_66_66_66_66_66_3C;
        font[7] = 96'h7E_7E_06_0C_18_30_30_30_30_30_30_30;
        font[8] = 96'h3C_66_66_66_3C_3C_66_66_66_66_66_3C;
        font[9] = 96'h3C_66_66_66_66_3E_06_06_06_06_66_3C;

        rst = 1'b1; x = '0; y = '0; frame_start = 1'b0; point = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_score0", 32'(score0), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_pix0", 32'(pix0), 0);
        rst = 1'b0;
        step();

        // three points, conversion length, then " 3" on the default instance
        x = 12'd900; y = 12'd900;
        point = 1'b1; repeat (3) step(); point = 1'b0; step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        n = 0;
        while (busy0 && n < 20) begin n++; step(); end
        chk("busy_len", 32'(n), 32'(SW + 1));
        for (int yy = 0; yy < 13; yy++)
            for (int xx = 0; xx < 30; xx++) begin
                x = 12'(xx); y = 12'(yy); step();
            end
        hold_xy(15, 0); chk("d3_row0_x15", 32'(pix0), 1);
        hold_xy(13, 0); chk("d3_row0_x13", 32'(pix0), 0);
        hold_xy(5, 0);  chk("lz_blank_cell0", 32'(pix0), 0);

        // saturate vs wrap
        clear = 1'b1; step(); clear = 1'b0;
        x = 12'd900; y = 12'd900;
        point = 1'b1; repeat (100) step();
        chk("sat_100", 32'(score0), 99);
        chk("wrap_100", 32'(score1), 0);
        step(); point = 1'b0;
        chk("sat_101", 32'(score0), 99);
        chk("wrap_101", 32'(score1), 1);
        pulse_frame_and_settle();
        for (int yy = 48; yy < 76; yy += 3)
            for (int xx = 98; xx < 140; xx++) begin
                x = 12'(xx); y = 12'(yy); step();
            end

        // scaled geometry, score 0 drawn as "00" on instance 1
        clear = 1'b1; step(); clear = 1'b0;
        pulse_frame_and_settle();
        for (int yy = 50; yy < 52; yy++)
            for (int xx = 100; xx < 116; xx++) begin
                hold_xy(xx, yy);
                chk("s1_row0", 32'(pix1), 32'(xx >= 104 && xx <= 111));
            end
        hold_xy(106, 74); chk("s1_below", 32'(pix1), 0);
        hold_xy(106, 73); chk("s1_lastrow", 32'(pix1), 1);

        // clear beats point; point during busy keeps the old display
        point = 1'b1; repeat (5) step(); point = 1'b0;
        point = 1'b1; clear = 1'b1; step(); point = 1'b0; clear = 1'b0;
        chk("clear_wins", 32'(score0), 0);
        point = 1'b1; repeat (5) step(); point = 1'b0;
        pulse_frame_and_settle();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        point = 1'b1; repeat (2) step(); point = 1'b0;
        repeat (4) step();
        hold_xy(13, 2); chk("old_5_shown", 32'(pix0), 1);
        repeat (4) step();
        hold_xy(13, 2); chk("still_5", 32'(pix0), 1);
        pulse_frame_and_settle();
        hold_xy(13, 2); chk("now_7_x13", 32'(pix0), 0);
        hold_xy(17, 2); chk("now_7_x17", 32'(pix0), 1);

        // frame_start while busy is ignored
        x = 12'd900; y = 12'd900;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        step(); step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        n = 0;
        while (busy0 && n < 20) begin n++; step(); end
        chk("no_restart", 32'(n), 5);
        repeat (10) step();

        // asynchronous reset in the middle of a conversion
        point = 1'b1; repeat (4) step(); point = 1'b0;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_score0", 32'(score0), 0);
        chk("midrst_busy0", 32'(busy0), 0);
        chk("midrst_score1", 32'(score1), 0);
        chk("midrst_busy1", 32'(busy1), 0);
        chk("midrst_pix0", 32'(pix0), 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            x = 12'($urandom_range(200, 4000)); y = 12'($urandom_range(100, 4000)); step();
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            point       = ($urandom_range(0, 3) == 0);
            clear       = ($urandom_range(0, 60) == 0);
            frame_start = ($urandom_range(0, 25) == 0);
            if ($urandom_range(0, 1) == 0) begin
                x = 12'($urandom_range(0, 30));  y = 12'($urandom_range(0, 13));
            end else begin
                x = 12'($urandom_range(96, 140)); y = 12'($urandom_range(46, 76));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
